reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised general-purpose register file with a per-register pending-write scoreboard.
- Serves the decode/writeback stages of the processor core. Provides NUM_RD combinational read ports, one synchronous write port, optional same-cycle write-to-read bypass, and busy tracking for multi-cycle producers such as loads.
- Next generation of the core's register file: width, depth and read-port count are generalised, and reset is a true clear.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written or reserved
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, combinational
rd_busy  out  NUM_RD  busy bit of each read address, combinational
we  in  1  write enable (writeback)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
resv_req  in  1  request to mark resv_addr pending (issue of multi-cycle op)
resv_addr  in  ADDR_W  register to reserve
resv_ok  out  1  combinational: reservation accepted this cycle
busy_cnt  out  ADDR_W+1  number of registers currently pending
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  debug read data, no bypass

Behaviour:
- Reset (rst=1, async): all registers = 0, all busy bits = 0, busy_cnt = 0. Outputs settle combinationally to 0 / resv_ok per rule below. Reset mid-operation discards all pending reservations.
- Write: on a rising edge with we=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. If ZERO_REG=1 and wr_addr=0, the write is ignored.
- Read port i: rd_data_i = reg[rd_addr_i]. If BYPASS=1, we=1 and wr_addr=rd_addr_i (and not the zero register), rd_data_i = wr_data instead.
- Zero register: address 0 with ZERO_REG=1 always reads 0, and its busy bit always reads 0.
- rd_busy_i = busy[rd_addr_i], except when BYPASS=1 and a same-cycle write targets that address without a same-cycle accepted reservation; then rd_busy_i = 0.
- resv_ok = resv_req and the target is not the zero register (when ZERO_REG=1) and one of the following holds:
  - busy[resv_addr]=0, or
  - we=1 and wr_addr=resv_addr (the old producer retires this cycle).
- Accepted reservation: on the edge, busy[resv_addr] <= 1.
- Rejected reservation: no state change. The issuer must stall and retry.
- Simultaneous write and accepted reservation to the same address: data is written, busy ends at 1 (reservation wins), busy_cnt unchanged.
- busy_cnt: +1 per accepted reservation of a non-busy register; -1 per write clearing a busy register; net 0 when both happen in the same cycle. It is never negative, and it saturates at 2**ADDR_W by construction. A write to a non-busy register does not change busy_cnt.
- Latency: write visible at read ports in the same cycle with BYPASS=1, otherwise the cycle after the edge. Busy visible the cycle after reservation.
- dbg_data = reg[dbg_addr] (stored value, zero-register rule applies), never bypassed.

Decomposition:
- Shared package holds:
  - rf_addr_t and rf_data_t typedefs sized from the core-wide DATA_W/ADDR_W constants
  - RF_ZERO_ADDR constant
- One natural sub-module: rf_scoreboard. It owns the busy vector, busy_cnt and the resv_ok logic. The top holds the storage array and the read/bypass muxes.

Test Plan:
- Assert rst mid-run after writing reg3=0xDEADBEEF and reserving reg5 -> reg3 reads 0, rd_busy for reg5 = 0, busy_cnt = 0 immediately, without waiting for a clock edge.
- Write reg7=0x00000014 with rd_addr0=7, BYPASS=1 -> rd_data0 = 0x14 in the write cycle; with BYPASS=0 -> old value in the write cycle and 0x14 the next cycle.
- we=1, wr_addr=0, wr_data=0xFFFFFFFF -> dbg_data for address 0 stays 0; resv_req to reg0 -> resv_ok=0, busy_cnt stays 0.
- Reserve reg4 (ok=1, busy_cnt=1), then reserve reg4 again -> resv_ok=0. Then write reg4=8 and reserve reg4 in the same cycle -> resv_ok=1, reg4=8, busy stays 1, busy_cnt=1.
- Reserve regs 1, 2, 3 in successive cycles, then write reg2 -> busy_cnt sequence 1, 2, 3, 2; rd_busy for reg2 = 0 with busy vector {1,0,1}.
- NUM_RD=4, all read ports addressing reg9 during a write of 0x55 -> all four rd_data = 0x55 (BYPASS=1).

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the register file and its scoreboard.
//   rf_addr_t / rf_data_t : register address / data at the core-wide width
//   RF_ZERO_ADDR          : address of the optional hardwired-zero register
package reg_file_sb_pkg;

   localparam int CORE_DATA_W = 32;
   localparam int CORE_ADDR_W = 5;

   typedef logic [CORE_DATA_W-1:0] rf_data_t;
   typedef logic [CORE_ADDR_W-1:0] rf_addr_t;

   localparam rf_addr_t RF_ZERO_ADDR = '0;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, a count of busy
// registers, and the reservation accept decision.
//   clk, rst            : clock, async active-high reset
//   rd_addr / rd_busy   : per read port address in, busy bit out (combinational)
//   we, wr_addr         : writeback, retires the pending producer
//   resv_req, resv_addr : reservation request from issue
//   resv_ok             : reservation accepted this cycle (combinational)
//   busy_cnt            : number of registers currently pending
module rf_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic                     resv_req,
   input  logic [ADDR_W-1:0]        resv_addr,
   output logic                     resv_ok,
   output logic [ADDR_W:0]          busy_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic             wr_clr, ok, inc, dec;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == ADDR_W'(RF_ZERO_ADDR));
   endfunction

   always_comb begin
      wr_clr = we && !is_zero(wr_addr);
      // A busy target is still acceptable if its producer retires this cycle.
      ok     = resv_req && !is_zero(resv_addr) &&
               (!busy_q[resv_addr] || (we && (wr_addr == resv_addr)));
      inc    = ok && !busy_q[resv_addr];
      // Same-address write+reservation keeps the bit set, so no decrement.
      dec    = wr_clr && busy_q[wr_addr] && !(ok && (resv_addr == wr_addr));

      busy_d = busy_q;
      if (wr_clr) busy_d[wr_addr] = 1'b0;
      if (ok)     busy_d[resv_addr] = 1'b1;

      cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
         if (is_zero(rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_busy[i] = 1'b0;
         end else if ((BYPASS != 0) && wr_clr &&
                      (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]) &&
                      !(ok && (resv_addr == wr_addr))) begin
            rd_busy[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign resv_ok  = ok;
   assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD combinational read ports, one synchronous write
// port, optional write-to-read bypass and a pending-write scoreboard.
//   clk, rst            : clock, async active-high reset (clears all state)
//   rd_addr / rd_data   : read ports, data combinational
//   rd_busy             : busy bit per read port
//   we, wr_addr, wr_data: writeback port
//   resv_req, resv_addr, resv_ok : reservation handshake
//   busy_cnt            : pending register count
//   dbg_addr / dbg_data : stored-value debug read, never bypassed
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     resv_req,
   input  logic [ADDR_W-1:0]        resv_addr,
   output logic                     resv_ok,
   output logic [ADDR_W:0]          busy_cnt,
   input  logic [ADDR_W-1:0]        dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_en;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == ADDR_W'(RF_ZERO_ADDR));
   endfunction

   assign wr_en = we && !is_zero(wr_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (is_zero(rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_data[i*DATA_W +: DATA_W] = '0;
         end else if ((BYPASS != 0) && wr_en &&
                      (wr_addr == rd_addr[i*ADDR_W +: ADDR_W])) begin
            rd_data[i*DATA_W +: DATA_W] = wr_data;
         end else begin
            rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
         end
      end
   end

   assign dbg_data = is_zero(dbg_addr) ? '0 : mem_q[dbg_addr];

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_busy   (rd_busy),
      .we        (we),
      .wr_addr   (wr_addr),
      .resv_req  (resv_req),
      .resv_addr (resv_addr),
      .resv_ok   (resv_ok),
      .busy_cnt  (busy_cnt)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] rd_addr_a;
   logic [127:0] rd_data_a;
   logic [3:0]  rd_busy_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_b;
   logic [0:0]  rd_busy_b;
   logic        we;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        resv_req;
   logic [4:0]  resv_addr;
   logic        resv_ok_a, resv_ok_b;
   logic [5:0]  busy_cnt_a, busy_cnt_b;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data_a, dbg_data_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Four read ports with bypass.
   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .resv_req(resv_req),
      .resv_addr(resv_addr), .resv_ok(resv_ok_a), .busy_cnt(busy_cnt_a),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data_a));

   // Single read port without bypass, same stimulus.
   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .resv_req(resv_req),
      .resv_addr(resv_addr), .resv_ok(resv_ok_b), .busy_cnt(busy_cnt_b),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; resv_req = 1'b0;
   endtask

   task automatic set_rd(input logic [4:0] a0, a1, a2, a3);
      rd_addr_a = {a3, a2, a1, a0};
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (rd_data_a !== 128'h0) begin n_err++; $display("FAIL reset_rd_data got=%h exp=0", rd_data_a); end
      n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL reset_busy_cnt got=%0d exp=0", busy_cnt_a); end
      n_cmp++; if (rd_busy_a !== 4'b0) begin n_err++; $display("FAIL reset_rd_busy got=%b exp=0000", rd_busy_a); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_bypass();
      we = 1'b1; wr_addr = 5'd7; wr_data = 32'h14;
      set_rd(5'd7, 5'd0, 5'd0, 5'd0); rd_addr_b = 5'd7;
      #1;
      n_cmp++; if (rd_data_a[31:0] !== 32'h14) begin n_err++; $display("FAIL bypass_same_cycle got=%h exp=00000014", rd_data_a[31:0]); end
      n_cmp++; if (rd_data_b !== 32'h0) begin n_err++; $display("FAIL nobypass_same_cycle got=%h exp=00000000", rd_data_b); end
      tick(); idle(); #1;
      n_cmp++; if (rd_data_b !== 32'h14) begin n_err++; $display("FAIL nobypass_next_cycle got=%h exp=00000014", rd_data_b); end
   endtask

   task automatic test_zero_reg();
      we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      set_rd(5'd0, 5'd0, 5'd0, 5'd0); dbg_addr = 5'd0;
      #1;
      n_cmp++; if (rd_data_a[31:0] !== 32'h0) begin n_err++; $display("FAIL zero_no_bypass got=%h exp=00000000", rd_data_a[31:0]); end
      tick(); idle(); #1;
      n_cmp++; if (dbg_data_a !== 32'h0) begin n_err++; $display("FAIL zero_dbg got=%h exp=00000000", dbg_data_a); end
      resv_req = 1'b1; resv_addr = 5'd0; #1;
      n_cmp++; if (resv_ok_a !== 1'b0) begin n_err++; $display("FAIL zero_resv_ok got=%b exp=0", resv_ok_a); end
      tick(); idle(); #1;
      n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL zero_busy_cnt got=%0d exp=0", busy_cnt_a); end
      n_cmp++; if (rd_busy_a[0] !== 1'b0) begin n_err++; $display("FAIL zero_rd_busy got=%b exp=0", rd_busy_a[0]); end
   endtask

   task automatic test_rereserve();
      set_rd(5'd4, 5'd0, 5'd0, 5'd0); dbg_addr = 5'd4;
      resv_req = 1'b1; resv_addr = 5'd4; #1;
      n_cmp++; if (resv_ok_a !== 1'b1) begin n_err++; $display("FAIL resv4_first_ok got=%b exp=1", resv_ok_a); end
      tick(); #1;
      n_cmp++; if (busy_cnt_a !== 6'd1) begin n_err++; $display("FAIL resv4_cnt got=%0d exp=1", busy_cnt_a); end
      n_cmp++; if (rd_busy_a[0] !== 1'b1) begin n_err++; $display("FAIL resv4_busy got=%b exp=1", rd_busy_a[0]); end
      n_cmp++; if (resv_ok_a !== 1'b0) begin n_err++; $display("FAIL resv4_again_ok got=%b exp=0", resv_ok_a); end
      tick(); #1;
      n_cmp++; if (busy_cnt_a !== 6'd1) begin n_err++; $display("FAIL resv4_rejected_cnt got=%0d exp=1", busy_cnt_a); end
      we = 1'b1; wr_addr = 5'd4; wr_data = 32'h8; #1;
      n_cmp++; if (resv_ok_a !== 1'b1) begin n_err++; $display("FAIL resv4_retire_ok got=%b exp=1", resv_ok_a); end
      n_cmp++; if (rd_busy_a[0] !== 1'b1) begin n_err++; $display("FAIL resv4_retire_busy_same got=%b exp=1", rd_busy_a[0]); end
      tick(); idle(); #1;
      n_cmp++; if (dbg_data_a !== 32'h8) begin n_err++; $display("FAIL resv4_data got=%h exp=00000008", dbg_data_a); end
      n_cmp++; if (rd_busy_a[0] !== 1'b1) begin n_err++; $display("FAIL resv4_busy_kept got=%b exp=1", rd_busy_a[0]); end
      n_cmp++; if (busy_cnt_a !== 6'd1) begin n_err++; $display("FAIL resv4_cnt_kept got=%0d exp=1", busy_cnt_a); end
      we = 1'b1; wr_addr = 5'd4; wr_data = 32'h9; #1;
      n_cmp++; if (rd_busy_a[0] !== 1'b0) begin n_err++; $display("FAIL resv4_clear_bypass_busy got=%b exp=0", rd_busy_a[0]); end
      tick(); idle(); #1;
      n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL resv4_clear_cnt got=%0d exp=0", busy_cnt_a); end
   endtask

   task automatic test_sequence();
      logic [5:0] exp_cnt [3];
      exp_cnt[0] = 6'd1; exp_cnt[1] = 6'd2; exp_cnt[2] = 6'd3;
      set_rd(5'd1, 5'd2, 5'd3, 5'd0);
      for (int i = 0; i < 3; i++) begin
         resv_req = 1'b1; resv_addr = 5'(i + 1);
         tick(); idle(); #1;
         n_cmp++; if (busy_cnt_a !== exp_cnt[i]) begin n_err++; $display("FAIL seq_cnt_%0d got=%0d exp=%0d", i, busy_cnt_a, exp_cnt[i]); end
      end
      we = 1'b1; wr_addr = 5'd2; wr_data = 32'h22; #1;
      n_cmp++; if (rd_busy_a[2:0] !== 3'b101) begin n_err++; $display("FAIL seq_busy_bypass got=%b exp=101", rd_busy_a[2:0]); end
      tick(); idle(); #1;
      n_cmp++; if (busy_cnt_a !== 6'd2) begin n_err++; $display("FAIL seq_cnt_after_write got=%0d exp=2", busy_cnt_a); end
      n_cmp++; if (rd_busy_a[2:0] !== 3'b101) begin n_err++; $display("FAIL seq_busy_stored got=%b exp=101", rd_busy_a[2:0]); end
   endtask

   task automatic test_back_to_back();
      // Retire reg1 and reserve reg6 together: count nets to zero change.
      set_rd(5'd1, 5'd6, 5'd0, 5'd0);
      we = 1'b1; wr_addr = 5'd1; wr_data = 32'h11;
      resv_req = 1'b1; resv_addr = 5'd6;
      tick(); idle(); #1;
      n_cmp++; if (busy_cnt_a !== 6'd2) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=2", busy_cnt_a); end
      n_cmp++; if (rd_busy_a[1:0] !== 2'b10) begin n_err++; $display("FAIL b2b_busy got=%b exp=10", rd_busy_a[1:0]); end
   endtask

   task automatic test_all_ports();
      set_rd(5'd9, 5'd9, 5'd9, 5'd9); rd_addr_b = 5'd9;
      we = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; #1;
      n_cmp++; if (rd_data_a !== {4{32'h55}}) begin n_err++; $display("FAIL allports_bypass got=%h exp=4x00000055", rd_data_a); end
      n_cmp++; if (rd_data_b !== 32'h0) begin n_err++; $display("FAIL allports_nobypass got=%h exp=00000000", rd_data_b); end
      tick(); idle(); #1;
      n_cmp++; if (rd_data_b !== 32'h55) begin n_err++; $display("FAIL allports_stored got=%h exp=00000055", rd_data_b); end
   endtask

   task automatic test_async_reset();
      we = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
      tick(); idle();
      resv_req = 1'b1; resv_addr = 5'd5;
      tick(); idle();
      set_rd(5'd3, 5'd5, 5'd0, 5'd0); dbg_addr = 5'd3; #1;
      n_cmp++; if (rd_data_a[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL prereset_data got=%h exp=deadbeef", rd_data_a[31:0]); end
      n_cmp++; if (busy_cnt_a !== 6'd2) begin n_err++; $display("FAIL prereset_cnt got=%0d exp=2", busy_cnt_a); end
      n_cmp++; if (rd_busy_a[1] !== 1'b1) begin n_err++; $display("FAIL prereset_busy5 got=%b exp=1", rd_busy_a[1]); end
      rst = 1'b1; #1;
      n_cmp++; if (rd_data_a[31:0] !== 32'h0) begin n_err++; $display("FAIL async_rst_data got=%h exp=00000000", rd_data_a[31:0]); end
      n_cmp++; if (dbg_data_a !== 32'h0) begin n_err++; $display("FAIL async_rst_dbg got=%h exp=00000000", dbg_data_a); end
      n_cmp++; if (rd_busy_a[1] !== 1'b0) begin n_err++; $display("FAIL async_rst_busy5 got=%b exp=0", rd_busy_a[1]); end
      n_cmp++; if (busy_cnt_a !== 6'd0) begin n_err++; $display("FAIL async_rst_cnt got=%0d exp=0", busy_cnt_a); end
      n_cmp++; if (busy_cnt_b !== 6'd0) begin n_err++; $display("FAIL async_rst_cnt_b got=%0d exp=0", busy_cnt_b); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; idle();
      wr_addr = '0; wr_data = '0; resv_addr = '0; dbg_addr = '0;
      rd_addr_a = '0; rd_addr_b = '0;
      test_reset();
      test_bypass();
      test_zero_reg();
      test_rereserve();
      test_sequence();
      test_back_to_back();
      test_all_ports();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
